// File: rtl/intr_pkg.sv
// Shared types and defaults for the interrupt controller slice.
package intr_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, TAKE, HOLDOFF} intr_state_t;

  localparam int DEF_NUM_SRC     = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam logic [DEF_NUM_SRC-1:0] DEF_EDGE_MASK = 4'b0001;
  localparam int CAUSE_W = $clog2(DEF_NUM_SRC);

endpackage

// File: rtl/intr_ctrl_if.sv
// Signal bundle between the core/CSR side (master) and the interrupt controller (slave).
interface intr_ctrl_if import intr_pkg::*; #(
  parameter int NUM_SRC = DEF_NUM_SRC
) ();

  localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] irq_in;
  logic [NUM_SRC-1:0] irq_en;
  logic               mstatus_3;
  logic               instr_boundary;
  logic               mret_exec;
  logic               int_taken;
  logic [CW-1:0]      int_cause;
  logic [NUM_SRC-1:0] int_pending;

  modport master (
    output irq_in, irq_en, mstatus_3, instr_boundary, mret_exec,
    input  int_taken, int_cause, int_pending
  );

  modport slave (
    input  irq_in, irq_en, mstatus_3, instr_boundary, mret_exec,
    output int_taken, int_cause, int_pending
  );

endinterface

// File: rtl/irq_sync.sv
// Single-bit multi-flop synchroniser for one asynchronous interrupt line.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronises lines, tracks pending requests, gates with
// MIE/enables and issues a single-cycle take at an instruction boundary.
module intr_ctrl import intr_pkg::*; #(
  parameter int                 NUM_SRC     = DEF_NUM_SRC,
  parameter int                 SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = DEF_EDGE_MASK
) (
  input  logic        clk,
  input  logic        reset_n,
  intr_ctrl_if.slave  bus
);

  localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  intr_state_t        state;
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] s_prev;
  logic [NUM_SRC-1:0] edge_pend;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] take_clear;
  logic [CW-1:0]      winner;
  logic [CW-1:0]      cause;
  logic               taken;
  logic               req;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bus.irq_in[g]),
      .q       (s[g])
    );
  end

  // Level sources follow the synchroniser directly; edge sources use the latch.
  assign pending = (edge_pend & EDGE_MASK) | (s & ~EDGE_MASK);
  assign active  = pending & bus.irq_en;
  assign req     = (|active) & bus.mstatus_3;

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) winner = CW'(i);
    end
  end

  always_comb begin
    take_clear = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      take_clear[i] = (state == TAKE) && (cause == CW'(i));
    end
  end

  // A fresh edge in the take cycle beats the clear, so that request is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_prev    <= '0;
      edge_pend <= '0;
    end else begin
      s_prev <= s;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (EDGE_MASK[i]) begin
          edge_pend[i] <= (s[i] & ~s_prev[i]) | (edge_pend[i] & ~take_clear[i]);
        end else begin
          edge_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      taken <= 1'b0;
      cause <= '0;
    end else begin
      taken <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) state <= ARMED;
        end
        ARMED: begin
          if (!req) begin
            state <= IDLE;
          end else if (bus.instr_boundary && !bus.mret_exec) begin
            state <= TAKE;
            taken <= 1'b1;
            cause <= winner;
          end
        end
        TAKE:    state <= HOLDOFF;
        HOLDOFF: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.int_taken   = taken;
  assign bus.int_cause   = cause;
  assign bus.int_pending = pending;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with a cycle-level reference model and literal spot checks.
module tb_intr_ctrl;
  import intr_pkg::*;

  localparam int             N  = 4;
  localparam int             SS = 2;
  localparam logic [N-1:0]   EM = 4'b0001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  intr_ctrl_if #(.NUM_SRC(N)) bus ();

  intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(SS), .EDGE_MASK(EM)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: lines delayed by SS cycles, pending per source, and a
  // "busy" countdown covering the take cycle plus one cool-down cycle.
  logic [N-1:0] m_line [SS];
  logic [N-1:0] m_sprev = '0;
  logic [N-1:0] m_edge = '0;
  logic [N-1:0] m_pend = '0;
  logic         m_taken = 1'b0;
  logic [1:0]   m_cause = '0;
  bit           m_wait = 1'b0;
  int           m_busy = 0;

  always @(posedge clk or negedge reset_n) begin : model
    logic [N-1:0] s_now;
    logic [N-1:0] eff;
    bit           req;
    bit           fire;
    int           win;
    if (!reset_n) begin
      for (int k = 0; k < SS; k++) m_line[k] = '0;
      m_sprev = '0; m_edge = '0; m_pend = '0;
      m_taken = 1'b0; m_cause = '0; m_wait = 1'b0; m_busy = 0;
    end else begin
      s_now = m_line[SS-1];
      eff   = m_pend & bus.irq_en;
      req   = (eff != '0) && bus.mstatus_3;
      win   = 0;
      for (int i = N - 1; i >= 0; i--) if (eff[i]) win = i;
      for (int i = 0; i < N; i++) begin
        if (EM[i]) m_edge[i] = (s_now[i] && !m_sprev[i]) || (m_edge[i] && !(m_taken && m_cause == 2'(i)));
      end
      m_sprev = s_now;
      for (int k = SS - 1; k > 0; k--) m_line[k] = m_line[k-1];
      m_line[0] = bus.irq_in;
      fire = 1'b0;
      if (m_busy > 0) begin
        m_busy = m_busy - 1;
        m_wait = 1'b0;
      end else if (!m_wait) begin
        m_wait = req;
      end else if (!req) begin
        m_wait = 1'b0;
      end else if (bus.instr_boundary && !bus.mret_exec) begin
        fire = 1'b1; m_cause = 2'(win); m_busy = 2; m_wait = 1'b0;
      end
      m_taken = fire;
      m_pend  = (m_edge & EM) | (m_line[SS-1] & ~EM);
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (bus.int_taken !== m_taken || bus.int_cause !== m_cause || bus.int_pending !== m_pend) begin
      miscompares++;
      $display("[TB] FAIL model_cycle t=%0t taken got %b exp %b, cause got %0d exp %0d, pending got %b exp %b",
               $time, bus.int_taken, m_taken, bus.int_cause, m_cause, bus.int_pending, m_pend);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [N-1:0] irq, input logic [N-1:0] en,
                                input logic mie, input logic bnd, input logic mret);
    bus.irq_in = irq; bus.irq_en = en; bus.mstatus_3 = mie;
    bus.instr_boundary = bnd; bus.mret_exec = mret;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic count_takes(input int k, output int c);
    c = 0;
    for (int i = 0; i < k; i++) begin
      step(1);
      if (bus.int_taken) c++;
    end
  endtask

  task automatic wait_take(input int max, output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (!seen && n < max) begin
      step(1);
      n++;
      if (bus.int_taken) seen = 1'b1;
    end
  endtask

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int  c;
    int  n;
    bit  seen;
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    step(2);
    check_output("reset_taken", 32'(bus.int_taken), 0);
    check_output("reset_cause", 32'(bus.int_cause), 0);
    check_output("reset_pending", 32'(bus.int_pending), 0);
    check_output("reset_state", 32'(dut.state), 32'(IDLE));
    reset_n = 1'b1;
    step(1);

    // Single edge pulse on source 0 with the boundary held high.
    apply_stimulus(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0);
    step(1);
    bus.irq_in = '0;
    step(1);
    check_output("edge_not_yet", 32'(bus.int_pending), 0);
    step(1);
    check_output("edge_pending", 32'(bus.int_pending), 32'h1);
    count_takes(8, c);
    check_output("edge_take_count", 32'(c), 1);
    check_output("edge_cause", 32'(bus.int_cause), 0);
    check_output("edge_cleared", 32'(bus.int_pending), 0);

    // Two level sources: lowest index wins; no take once MIE is dropped.
    apply_stimulus(4'b0110, 4'b1111, 1'b1, 1'b0, 1'b0);
    step(4);
    check_output("level_pending", 32'(bus.int_pending), 32'h6);
    check_output("level_armed", 32'(dut.state), 32'(ARMED));
    bus.instr_boundary = 1'b1;
    step(1);
    check_output("level_taken", 32'(bus.int_taken), 1);
    check_output("level_cause", 32'(bus.int_cause), 1);
    bus.instr_boundary = 1'b0; bus.mstatus_3 = 1'b0;
    step(3);
    bus.instr_boundary = 1'b1;
    count_takes(4, c);
    check_output("mie_off_takes", 32'(c), 0);
    apply_stimulus('0, 4'b1111, 1'b0, 1'b0, 1'b0);
    step(4);
    check_output("level_released", 32'(bus.int_pending), 0);

    // Pending source masked by irq_en stays idle until enabled.
    apply_stimulus(4'b0100, 4'b1011, 1'b1, 1'b0, 1'b0);
    step(4);
    check_output("gate_pending", 32'(bus.int_pending), 32'h4);
    bus.instr_boundary = 1'b1;
    count_takes(3, c);
    check_output("gate_takes", 32'(c), 0);
    check_output("gate_idle", 32'(dut.state), 32'(IDLE));
    bus.irq_en = 4'b1111;
    step(1);
    check_output("gate_armed", 32'(dut.state), 32'(ARMED));
    step(1);
    check_output("gate_taken", 32'(bus.int_taken), 1);
    check_output("gate_cause", 32'(bus.int_cause), 2);
    bus.instr_boundary = 1'b0; bus.mstatus_3 = 1'b0;
    step(3);
    bus.irq_in = '0;
    step(3);

    // mret at a boundary defers the take to the following boundary.
    apply_stimulus(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
    step(4);
    check_output("mret_armed", 32'(dut.state), 32'(ARMED));
    bus.instr_boundary = 1'b1; bus.mret_exec = 1'b1;
    step(1);
    check_output("mret_no_take", 32'(bus.int_taken), 0);
    check_output("mret_still_armed", 32'(dut.state), 32'(ARMED));
    bus.instr_boundary = 1'b0; bus.mret_exec = 1'b0;
    step(1);
    bus.instr_boundary = 1'b1;
    step(1);
    check_output("mret_taken", 32'(bus.int_taken), 1);
    check_output("mret_cause", 32'(bus.int_cause), 3);
    apply_stimulus('0, 4'b1000, 1'b0, 1'b0, 1'b0);
    step(4);

    // Asynchronous reset while armed with an edge request pending.
    apply_stimulus(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(1);
    bus.irq_in = '0;
    step(3);
    check_output("rst_pre_armed", 32'(dut.state), 32'(ARMED));
    check_output("rst_pre_pending", 32'(bus.int_pending), 32'h1);
    check_output("rst_pre_cause", 32'(bus.int_cause), 3);
    reset_n = 1'b0;
    #1;
    check_output("rst_async_pending", 32'(bus.int_pending), 0);
    check_output("rst_async_cause", 32'(bus.int_cause), 0);
    step(1);
    check_output("rst_taken", 32'(bus.int_taken), 0);
    check_output("rst_state", 32'(dut.state), 32'(IDLE));
    reset_n = 1'b1;
    step(2);

    // A new edge on source 0 landing in its own take cycle survives the clear.
    apply_stimulus(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0);
    step(1);
    bus.irq_in = '0;
    step(2);
    bus.irq_in = 4'b0001;
    step(1);
    check_output("sim_armed", 32'(dut.state), 32'(ARMED));
    bus.irq_in = '0;
    step(1);
    check_output("sim_first_take", 32'(bus.int_taken), 1);
    check_output("sim_first_cause", 32'(bus.int_cause), 0);
    bus.mstatus_3 = 1'b0;
    step(1);
    check_output("sim_pending_kept", 32'(bus.int_pending), 32'h1);
    check_output("sim_holdoff", 32'(dut.state), 32'(HOLDOFF));
    bus.mstatus_3 = 1'b1;
    wait_take(6, n, seen);
    check_output("sim_second_seen", 32'(seen), 1);
    check_output("sim_take_gap", 32'(n + 1), 4);
    bus.instr_boundary = 1'b0; bus.mstatus_3 = 1'b0;
    step(3);
    check_output("sim_final_pending", 32'(bus.int_pending), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller directly upstream of the CSR block.
- Synchronises external interrupt lines and tracks pending requests per source (edge or level).
- Gates requests with the global MIE bit (mstatus_3) and a per-source enable, and picks a winner by fixed priority.
- At an instruction boundary, emits the single-cycle int_taken pulse that the CSR uses to save PC into mepc and clear MIE. Also supplies the winning cause to the trap logic.

Parameters:
NUM_SRC, 4, number of interrupt sources; index 0 is highest priority.
SYNC_STAGES, 2, flip-flop depth of the per-line synchroniser; minimum 2.
EDGE_MASK, 4'b0001, per-source mode: 1 = rising-edge latched, 0 = level.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
irq_in  in  NUM_SRC  raw asynchronous interrupt lines.
irq_en  in  NUM_SRC  per-source enable (mie-style mask).
mstatus_3  in  1  global MIE bit from the CSR.
instr_boundary  in  1  high for one cycle when the core may redirect the PC.
mret_exec  in  1  mret executing this cycle.
int_taken  out  1  one-cycle pulse to the CSR and PC mux.
int_cause  out  $clog2(NUM_SRC)  index of the taken source; holds until the next take.
int_pending  out  NUM_SRC  raw pending vector (before enable/MIE gating).

Behaviour:
- Reset (asynchronous, reset_n=0): all synchroniser flops, edge-detect flops and pending bits are 0; FSM goes to IDLE; int_taken=0; int_cause=0. Reset wins over every other event, including mid-take.
- Synchroniser: each irq_in passes through SYNC_STAGES flops, giving the signal s[i]. Latency from irq_in to pending is SYNC_STAGES+1 cycles for edge sources and SYNC_STAGES cycles for level sources.
- Edge sources: a rising s[i] (s[i]=1, previous 0) sets pending[i]. The bit clears only in the TAKE cycle when i is the winner. A new edge in that same TAKE cycle wins, so pending stays 1.
- Level sources: pending[i]=s[i]; they are never cleared by the controller.
- Request: req = |(pending & irq_en) & mstatus_3. The winner is the lowest set index of pending&irq_en.
- FSM states: IDLE, ARMED, TAKE, HOLDOFF.
  - IDLE -> ARMED when req=1.
  - ARMED -> IDLE when req=0 (MIE dropped or source vanished); nothing is emitted.
  - ARMED -> TAKE when instr_boundary=1, mret_exec=0 and req=1. The winner is re-evaluated in this same cycle.
  - ARMED with instr_boundary=1 and mret_exec=1: stay in ARMED. mret has priority, and the take is deferred to the next boundary.
  - TAKE: int_taken=1 for exactly this cycle; int_cause is registered with the winner; the edge pending bit of the winner is cleared. Unconditional -> HOLDOFF.
  - HOLDOFF: one cycle that lets the CSR's MIE clear propagate back on mstatus_3. Unconditional -> IDLE.
- Consequence: back-to-back takes are at least 3 cycles apart, and no second take can occur while MIE=0.
- mret_exec has no effect in IDLE, TAKE or HOLDOFF.
- int_pending is registered; int_taken is a Moore output of the TAKE state.
- Outputs never go X after reset; irq_en changes take effect in the same cycle.

Decomposition:
- Shared package intr_pkg:
  - state enum intr_state_t {IDLE, ARMED, TAKE, HOLDOFF};
  - CAUSE_W = $clog2(NUM_SRC);
  - localparam for the default EDGE_MASK.
- One natural sub-module: irq_sync (a parameterised SYNC_STAGES-deep single-bit synchroniser), instantiated NUM_SRC times via a generate loop.
- Priority encoder and FSM stay in intr_ctrl.

Test Plan:
1. Reset: reset_n=0 mid-ARMED with pending=4'b0001 -> next cycle int_taken=0, int_pending=0, int_cause=0, FSM in IDLE.
2. Edge source: MIE=1, irq_en=4'b0001, pulse irq_in[0] for 1 cycle, instr_boundary held high -> pending[0] set after 3 cycles, int_taken pulses once, int_cause=0, pending[0] cleared; no second pulse.
3. Priority with level source: irq_in=4'b0110 (level), irq_en=4'b1111, MIE=1, boundary pulse -> int_cause=1. Drop MIE and pulse boundary again -> no int_taken.
4. Gating: pending=4'b0100 with irq_en=4'b1011 -> never leaves IDLE. Set irq_en[2]=1 -> ARMED next cycle, and the take occurs at the next boundary.
5. mret conflict: in ARMED, assert instr_boundary and mret_exec together -> int_taken=0 and FSM stays ARMED. The next boundary without mret gives int_taken=1.
6. Simultaneous edge: new rising edge on source 0 lands in its own TAKE cycle -> pending[0] remains 1. After HOLDOFF, with MIE restored, a second take occurs, 3 or more cycles after the first.
